wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 32 +++
 rtl/rr_multi_grant.sv | 41 ++++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback arbiter: registered wb payload and active-list age compare.
// AL_SIZE defaults to 32 entries when not supplied by the build.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package wb_arbiter_pkg;

    localparam int unsigned PRD_MAX_W = 16;
    localparam int unsigned AL_MAX_W  = 16;

    typedef struct packed {
        logic [PRD_MAX_W-1:0] prd;
        logic [31:0]          data;
        logic [AL_MAX_W-1:0]  al_addr;
    } wb_payload_t;

    // True when a is at least as old as b, both measured from back modulo 2**al_w.
    function automatic logic al_older_or_equal(input logic [AL_MAX_W-1:0] a,
                                               input logic [AL_MAX_W-1:0] b,
                                               input logic [AL_MAX_W-1:0] back,
                                               input int unsigned         al_w);
        logic [AL_MAX_W-1:0] mask;
        logic [AL_MAX_W-1:0] rel_a;
        logic [AL_MAX_W-1:0] rel_b;
        mask  = AL_MAX_W'((32'd1 << al_w) - 32'd1);
        rel_a = (a - back) & mask;
        rel_b = (b - back) & mask;
        return rel_a <= rel_b;
    endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant: picks up to NUM_WB requesters scanning upward from start,
// returning the grant vector, the port each grant lands on and the last granted index.
module rr_multi_grant #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned NUM_WB  = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned PORT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant,
    output logic [PORT_W-1:0]  req_port [NUM_REQ],
    output logic [IDX_W-1:0]   last_grant
);

    always_comb begin
        int unsigned        cnt;
        int unsigned        pos;
        logic [IDX_W-1:0]   idx;
        grant      = '0;
        last_grant = start;
        cnt        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_port[i] = '0;
        end
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(start) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (req[idx] && (cnt < NUM_WB)) begin
                grant[idx]    = 1'b1;
                req_port[idx] = PORT_W'(cnt);
                last_grant    = idx;
                cnt           = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to NUM_WB functional-unit results per cycle, drops recalled ops.
// Optional perf counters are built when WB_ARB_PERF_EN is defined.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned NUM_WB  = 4,
    parameter int unsigned PRD_W   = 7,
    parameter int unsigned AL_W    = $clog2(`AL_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ext_stall,
    input  logic                if_recall,
    input  logic [AL_W-1:0]     new_front,
    input  logic [AL_W-1:0]     back,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [PRD_W-1:0]    req_prd     [NUM_REQ],
    input  logic [31:0]         req_data    [NUM_REQ],
    input  logic [AL_W-1:0]     req_al_addr [NUM_REQ],
    output logic [NUM_WB-1:0]   wb_valid,
    output logic [PRD_W-1:0]    wb_prd      [NUM_WB],
    output logic [31:0]         wb_data     [NUM_WB],
    output logic [AL_W-1:0]     wb_al_addr  [NUM_WB]
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cycles,
    output logic [31:0]         perf_grants
`endif
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PORT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] squash;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [PORT_W-1:0]  req_port [NUM_REQ];
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_WB-1:0]  wb_valid_d, wb_valid_q;
    wb_payload_t        wb_d [NUM_WB];
    wb_payload_t        wb_q [NUM_WB];
    logic               unused_wb;

    // Stall and reset block every grant; squashed ops never compete for a port.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            squash[i] = if_recall && al_older_or_equal(AL_MAX_W'(new_front),
                                                       AL_MAX_W'(req_al_addr[i]),
                                                       AL_MAX_W'(back), AL_W);
            elig[i]   = reset && !ext_stall && req_valid[i] && !squash[i];
        end
    end

    rr_multi_grant #(
        .NUM_REQ (NUM_REQ),
        .NUM_WB  (NUM_WB)
    ) u_rr_multi_grant (
        .req        (elig),
        .start      (rr_ptr_q),
        .grant      (grant),
        .req_port   (req_port),
        .last_grant (last_grant)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset && !ext_stall && ((req_valid[i] && squash[i]) || grant[i]);
        end
    end

    always_comb begin
        wb_valid_d = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_d[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (req_port[i] == PORT_W'(k))) begin
                    wb_valid_d[k]   = 1'b1;
                    wb_d[k].prd     = PRD_MAX_W'(req_prd[i]);
                    wb_d[k].data    = req_data[i];
                    wb_d[k].al_addr = AL_MAX_W'(req_al_addr[i]);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            rr_ptr_d = (last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= '0;
            for (int k = 0; k < NUM_WB; k++) begin
                wb_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            for (int k = 0; k < NUM_WB; k++) begin
                wb_q[k] <= wb_d[k];
            end
        end
    end

    assign wb_valid = wb_valid_q;

    always_comb begin
        unused_wb = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_prd[k]     = wb_q[k].prd[PRD_W-1:0];
            wb_data[k]    = wb_q[k].data;
            wb_al_addr[k] = wb_q[k].al_addr[AL_W-1:0];
            unused_wb     = unused_wb ^ (^wb_q[k]);
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_q, conflict_d;
    logic [31:0] grants_q, grants_d;
    logic [32:0] grants_sum;

    always_comb begin
        conflict_d = conflict_q;
        if (!ext_stall && ($countones(req_valid & ~squash) > NUM_WB) && (conflict_q != '1)) begin
            conflict_d = conflict_q + 32'd1;
        end
        grants_sum = {1'b0, grants_q} + 33'($countones(grant));
        grants_d   = grants_sum[32] ? '1 : grants_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_q <= '0;
            grants_q   <= '0;
        end else begin
            conflict_q <= conflict_d;
            grants_q   <= grants_d;
        end
    end

    assign perf_conflict_cycles = conflict_q;
    assign perf_grants          = grants_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter with immediate-assertion checks.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module tb_wb_arbiter;

    localparam int NUM_REQ = 6;
    localparam int NUM_WB  = 4;
    localparam int PRD_W   = 7;
    localparam int AL_W    = $clog2(`AL_SIZE);

    logic               clk = 1'b0;
    logic               reset;
    logic               ext_stall;
    logic               if_recall;
    logic [AL_W-1:0]    new_front;
    logic [AL_W-1:0]    back;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [PRD_W-1:0]   req_prd     [NUM_REQ];
    logic [31:0]        req_data    [NUM_REQ];
    logic [AL_W-1:0]    req_al_addr [NUM_REQ];
    logic [NUM_WB-1:0]  wb_valid;
    logic [PRD_W-1:0]   wb_prd      [NUM_WB];
    logic [31:0]        wb_data     [NUM_WB];
    logic [AL_W-1:0]    wb_al_addr  [NUM_WB];
`ifdef WB_ARB_PERF_EN
    logic [31:0]        perf_conflict_cycles;
    logic [31:0]        perf_grants;
`endif

    typedef struct {
        logic [NUM_WB-1:0]            valid;
        logic [NUM_WB-1:0][PRD_W-1:0] prd;
        logic [NUM_WB-1:0][31:0]      data;
        logic [NUM_WB-1:0][AL_W-1:0]  al;
        logic [2:0]                   rr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_WB  (NUM_WB),
        .PRD_W   (PRD_W),
        .AL_W    (AL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_stall   (ext_stall),
        .if_recall   (if_recall),
        .new_front   (new_front),
        .back        (back),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_prd     (req_prd),
        .req_data    (req_data),
        .req_al_addr (req_al_addr),
        .wb_valid    (wb_valid),
        .wb_prd      (wb_prd),
        .wb_data     (wb_data),
        .wb_al_addr  (wb_al_addr)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflict_cycles (perf_conflict_cycles),
        .perf_grants          (perf_grants)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_payload(input int seed);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_prd[i]     = PRD_W'(seed * 8 + i + 1);
            req_data[i]    = 32'hC0DE_0000 + 32'(seed * 16 + i);
            req_al_addr[i] = AL_W'(i);
        end
    endtask

    // sel holds the requester placed on each port, one nibble per port (port 0 lowest), F = idle.
    task automatic step(input string tag, input logic [5:0] valid, input logic [5:0] exp_ready,
                        input logic [15:0] sel, input logic [2:0] exp_rr);
        exp_t       e;
        logic [3:0] r;
        req_valid = valid;
        #1;
        chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_ready));
        e.valid = '0;
        e.prd   = '0;
        e.data  = '0;
        e.al    = '0;
        e.rr    = exp_rr;
        for (int k = 0; k < NUM_WB; k++) begin
            r = sel[4*k +: 4];
            if (r != 4'hF) begin
                e.valid[k] = 1'b1;
                e.prd[k]   = req_prd[r];
                e.data[k]  = req_data[r];
                e.al[k]    = req_al_addr[r];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " wb_valid"}, 64'(wb_valid), 64'(e.valid));
            for (int k = 0; k < NUM_WB; k++) begin
                if (e.valid[k]) begin
                    chk($sformatf("%s wb_prd[%0d]", tag, k), 64'(wb_prd[k]), 64'(e.prd[k]));
                    chk($sformatf("%s wb_data[%0d]", tag, k), 64'(wb_data[k]), 64'(e.data[k]));
                    chk($sformatf("%s wb_al[%0d]", tag, k), 64'(wb_al_addr[k]), 64'(e.al[k]));
                end
            end
            chk({tag, " rr_ptr"}, 64'(dut.rr_ptr_q), 64'(e.rr));
        end
    endtask

    initial begin
        reset     = 1'b0;
        ext_stall = 1'b0;
        if_recall = 1'b0;
        new_front = '0;
        back      = '0;
        req_valid = 6'h3F;
        set_payload(1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'h0);
        chk("reset wb_valid", 64'(wb_valid), 64'h0);
        chk("reset wb_prd0", 64'(wb_prd[0]), 64'h0);
        chk("reset wb_data0", 64'(wb_data[0]), 64'h0);
        chk("reset wb_al0", 64'(wb_al_addr[0]), 64'h0);
        chk("reset rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        reset = 1'b1;

        set_payload(2);
        step("all6_a", 6'h3F, 6'h0F, 16'h3210, 3'd4);
        set_payload(3);
        step("all6_b", 6'h3F, 6'h33, 16'h1054, 3'd2);
        set_payload(4);
        step("two_req", 6'h24, 6'h24, 16'hFF52, 3'd0);

        set_payload(5);
        back = AL_W'(10);
        new_front = AL_W'(14);
        if_recall = 1'b1;
        req_al_addr[0] = AL_W'(12);
        req_al_addr[1] = AL_W'(14);
        req_al_addr[2] = AL_W'(20);
        req_al_addr[3] = AL_W'(3);
        step("recall", 6'h0F, 6'h0F, 16'hFFF0, 3'd1);

        back = AL_W'(30);
        new_front = AL_W'(2);
        req_al_addr[0] = AL_W'(31);
        req_al_addr[1] = AL_W'(2);
        step("recall_wrap", 6'h03, 6'h03, 16'hFFF0, 3'd1);

        set_payload(6);
        req_al_addr[1] = AL_W'(2);
        ext_stall = 1'b1;
        step("stall", 6'h0B, 6'h00, 16'hFFFF, 3'd1);
        ext_stall = 1'b0;
        if_recall = 1'b0;
        step("stall_release", 6'h0B, 6'h0B, 16'hF031, 3'd1);

        set_payload(7);
        reset = 1'b0;
        step("mid_reset", 6'h3F, 6'h00, 16'hFFFF, 3'd0);
        reset = 1'b1;

        set_payload(8);
        step("restart_a", 6'h3F, 6'h0F, 16'h3210, 3'd4);
        set_payload(9);
        step("restart_b", 6'h3F, 6'h33, 16'h1054, 3'd2);
        set_payload(10);
        step("restart_c", 6'h3F, 6'h3C, 16'h5432, 3'd0);
        set_payload(11);
        step("restart_d", 6'h3F, 6'h0F, 16'h3210, 3'd4);
        set_payload(12);
        step("restart_e", 6'h3F, 6'h33, 16'h1054, 3'd2);

`ifdef WB_ARB_PERF_EN
        chk("perf_conflict_cycles", 64'(perf_conflict_cycles), 64'd5);
        chk("perf_grants", 64'(perf_grants), 64'd20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
